// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus used by memory_stage.
// The master side issues requests; the slave side is the data memory.
interface memory_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: issues loads/stores over a
// req/ack bus, stalls upstream while an access is outstanding, aligns and
// extends load data, and registers the MEM/WB signals for writeback_stage.
// Optional macro MEM_TIMEOUT_EN aborts an access left unacknowledged for
// TIMEOUT_CYCLES wait cycles and pulses bus_err_o.
module memory_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    input  logic           rf_we_i,
    input  logic [31:0]    rf_waddr_i,
    input  logic           mem_re_i,
    input  logic           mem_we_i,
    input  logic [1:0]     mem_size_i,
    input  logic           mem_unsigned_i,
    input  logic [31:0]    alu_result_i,
    input  logic [31:0]    store_data_i,
    output logic           stall_o,
    memory_stage_if.master dmem,
    output logic           rf_we_o,
    output logic [31:0]    rf_waddr_o,
    output logic           mem2rf_o,
    output logic [31:0]    mem_rdata_o,
    output logic [31:0]    alu_result_o,
    output logic           misalign_o,
    output logic           bus_err_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic        is_mem, aligned, access, misaligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic        req, complete;

    // Request latches held across wait states
    logic [31:0] addr_q, wdata_q, waddr_q;
    logic [3:0]  be_q;
    logic [1:0]  size_q;
    logic        we_q, uns_q, rf_we_in_q;

    // Current request fields: live inputs in IDLE, latches in WAIT
    logic        in_wait;
    logic [31:0] sel_addr, sel_wdata, sel_waddr;
    logic [3:0]  sel_be;
    logic [1:0]  sel_size;
    logic        sel_we, sel_uns, sel_rf_we;

    // MEM/WB pipeline registers
    logic        rf_we_q, rf_we_d, mem2rf_q, mem2rf_d, misalign_q, misalign_d;
    logic [31:0] waddr_out_q, waddr_out_d, rdata_q, rdata_d, alu_q, alu_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;
    logic             bus_err_q;
`endif

    function automatic logic [31:0] align_load(input logic [31:0] rd,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   res = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Alignment check and store lane formatting from the live inputs
    always_comb begin
        aligned  = 1'b1;
        be_in    = '0;
        wdata_in = store_data_i;
        case (mem_size_i)
            2'b00: begin
                be_in    = 4'b0001 << alu_result_i[1:0];
                wdata_in = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                aligned  = ~alu_result_i[0];
                be_in    = 4'b0011 << alu_result_i[1:0];
                wdata_in = {2{store_data_i[15:0]}};
            end
            default: begin
                aligned  = (alu_result_i[1:0] == 2'b00);
                be_in    = 4'b1111;
            end
        endcase
        if (!mem_we_i) be_in = '0;
    end

    assign is_mem     = valid_i & (mem_re_i | mem_we_i);
    assign access     = is_mem & aligned;
    assign misaligned = is_mem & ~aligned;

    assign in_wait   = (state_q == WAIT);
    assign sel_addr  = in_wait ? addr_q     : alu_result_i;
    assign sel_wdata = in_wait ? wdata_q    : wdata_in;
    assign sel_be    = in_wait ? be_q       : be_in;
    assign sel_size  = in_wait ? size_q     : mem_size_i;
    assign sel_we    = in_wait ? we_q       : mem_we_i;
    assign sel_uns   = in_wait ? uns_q      : mem_unsigned_i;
    assign sel_rf_we = in_wait ? rf_we_in_q : rf_we_i;
    assign sel_waddr = in_wait ? waddr_q    : rf_waddr_i;

    // Next state, request and stall; reset masks everything in its own cycle
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        stall_o  = 1'b0;
        complete = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timeout  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (dmem.dmem_ack_i) begin
                        complete = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem.dmem_ack_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    stall_o = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
        endcase
        if (rst) begin
            state_d  = IDLE;
            req      = 1'b0;
            stall_o  = 1'b0;
            complete = 1'b0;
`ifdef MEM_TIMEOUT_EN
            timeout  = 1'b0;
`endif
        end
    end

    assign dmem.dmem_req_o   = req;
    assign dmem.dmem_we_o    = sel_we;
    assign dmem.dmem_addr_o  = {sel_addr[31:2], 2'b00};
    assign dmem.dmem_be_o    = sel_be;
    assign dmem.dmem_wdata_o = sel_wdata;

    // MEM/WB next values: bubble unless something completes this cycle
    always_comb begin
        rf_we_d     = 1'b0;
        mem2rf_d    = 1'b0;
        misalign_d  = 1'b0;
        waddr_out_d = sel_waddr;
        alu_d       = sel_addr;
        rdata_d     = align_load(dmem.dmem_rdata_i, sel_addr[1:0], sel_size, sel_uns);
        if (complete) begin
            rf_we_d  = sel_rf_we;
            mem2rf_d = ~sel_we;
        end else if (state_q == IDLE && valid_i && !mem_re_i && !mem_we_i) begin
            rf_we_d = rf_we_i;
        end else if (state_q == IDLE && misaligned) begin
            misalign_d = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Capture the request when it has to wait for the memory
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            be_q       <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            rf_we_in_q <= 1'b0;
        end else if (state_q == IDLE && access && !dmem.dmem_ack_i) begin
            addr_q     <= alu_result_i;
            wdata_q    <= wdata_in;
            waddr_q    <= rf_waddr_i;
            be_q       <= be_in;
            size_q     <= mem_size_i;
            we_q       <= mem_we_i;
            uns_q      <= mem_unsigned_i;
            rf_we_in_q <= rf_we_i;
        end
    end

    // MEM/WB pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q     <= 1'b0;
            mem2rf_q    <= 1'b0;
            misalign_q  <= 1'b0;
            waddr_out_q <= '0;
            rdata_q     <= '0;
            alu_q       <= '0;
        end else begin
            rf_we_q     <= rf_we_d;
            mem2rf_q    <= mem2rf_d;
            misalign_q  <= misalign_d;
            waddr_out_q <= waddr_out_d;
            rdata_q     <= rdata_d;
            alu_q       <= alu_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait counter: cleared in IDLE, counts unacknowledged WAIT cycles
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) cnt_q <= '0;
        else if (!dmem.dmem_ack_i)  cnt_q <= cnt_q + CNT_W'(1);
    end

    // One-cycle bus error flag on an aborted access
    always_ff @(posedge clk) begin
        if (rst) bus_err_q <= 1'b0;
        else     bus_err_q <= timeout;
    end

    assign bus_err_o = bus_err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = waddr_out_q;
    assign mem2rf_o     = mem2rf_q;
    assign mem_rdata_o  = rdata_q;
    assign alu_result_o = alu_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: acts as both the upstream pipeline
// and the data memory, and compares every cycle against a behavioural model.
module tb_memory_stage;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, rf_we_i, mem_re_i, mem_we_i, mem_unsigned_i;
    logic [31:0] rf_waddr_i, alu_result_i, store_data_i;
    logic [1:0]  mem_size_i;
    logic        stall_o, rf_we_o, mem2rf_o, misalign_o, bus_err_o;
    logic [31:0] rf_waddr_o, mem_rdata_o, alu_result_o;

    memory_stage_if bus();

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .rf_we_i(rf_we_i),
        .rf_waddr_i(rf_waddr_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .stall_o(stall_o), .dmem(bus), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .mem2rf_o(mem2rf_o), .mem_rdata_o(mem_rdata_o),
        .alu_result_o(alu_result_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;

    // kind: 0 = ALU op, 1 = load, 2 = store; lat < 0 means never acknowledged
    typedef struct {
        bit          valid;
        int          kind;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] data;
        bit          rfwe;
        logic [31:0] waddr;
        int          lat;
        bit          rdfix;
        logic [31:0] rdv;
    } instr_t;

    function automatic instr_t mk(bit valid, int kind, logic [1:0] size, bit uns,
                                  logic [31:0] addr, logic [31:0] data, bit rfwe,
                                  logic [31:0] waddr, int lat);
        instr_t t;
        t.valid = valid; t.kind = kind; t.size = size; t.uns = uns;
        t.addr = addr; t.data = data; t.rfwe = rfwe; t.waddr = waddr;
        t.lat = lat; t.rdfix = 1'b0; t.rdv = '0;
        return t;
    endfunction

    // Reference rules, written arithmetically
    function automatic bit m_aligned(logic [1:0] size, logic [31:0] a);
        if (size == 2'b00) return 1'b1;
        if (size == 2'b01) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] size, logic [31:0] a);
        int unsigned off = a % 4;
        if (size == 2'b00) return 4'(1 << off);
        if (size == 2'b01) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] size, logic [31:0] d);
        if (size == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (size == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] size, bit uns, logic [31:0] a,
                                           logic [31:0] rd);
        int unsigned off = a % 4;
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_wb(string tag, bit rfwe, bit m2r, bit mis, bit berr,
                          logic [31:0] waddr, logic [31:0] alu, logic [31:0] rdata);
        chk({tag, ".rf_we_o"},    32'(rf_we_o),    32'(rfwe));
        chk({tag, ".mem2rf_o"},   32'(mem2rf_o),   32'(m2r));
        chk({tag, ".misalign_o"}, 32'(misalign_o), 32'(mis));
        chk({tag, ".bus_err_o"},  32'(bus_err_o),  32'(berr));
        if (rfwe || m2r) begin
            chk({tag, ".rf_waddr_o"},   rf_waddr_o,   waddr);
            chk({tag, ".alu_result_o"}, alu_result_o, alu);
        end
        if (m2r) chk({tag, ".mem_rdata_o"}, mem_rdata_o, rdata);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, ".rf_we_o"},      32'(rf_we_o),    32'd0);
        chk({tag, ".rf_waddr_o"},   rf_waddr_o,      32'd0);
        chk({tag, ".mem2rf_o"},     32'(mem2rf_o),   32'd0);
        chk({tag, ".mem_rdata_o"},  mem_rdata_o,     32'd0);
        chk({tag, ".alu_result_o"}, alu_result_o,    32'd0);
        chk({tag, ".misalign_o"},   32'(misalign_o), 32'd0);
        chk({tag, ".bus_err_o"},    32'(bus_err_o),  32'd0);
    endtask

    task automatic drive(instr_t in);
        valid_i        = in.valid;
        rf_we_i        = in.rfwe;
        rf_waddr_i     = in.waddr;
        mem_re_i       = (in.kind == 1);
        mem_we_i       = (in.kind == 2);
        mem_size_i     = in.size;
        mem_unsigned_i = in.uns;
        alu_result_i   = in.addr;
        store_data_i   = in.data;
    endtask

    // Present one instruction, play the memory, and check every cycle
    task automatic run_instr(string tag, instr_t in);
        bit          mem = in.valid && (in.kind != 0);
        bit          acc = mem && m_aligned(in.size, in.addr);
        int          last = acc ? ((in.lat < 0) ? int'(TO) : in.lat) : 0;
        logic [31:0] rd = '0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            drive(in);
            bus.dmem_ack_i   = acc ? (c == in.lat) : ($urandom_range(0, 3) == 0);
            bus.dmem_rdata_i = in.rdfix ? in.rdv : $urandom;
            rd = bus.dmem_rdata_i;
            #1;
            chk({tag, ".req"},   32'(bus.dmem_req_o), 32'(acc));
            chk({tag, ".stall"}, 32'(stall_o),        32'(acc && c != in.lat));
            if (acc) begin
                chk({tag, ".addr"}, bus.dmem_addr_o, in.addr & 32'hFFFF_FFFC);
                chk({tag, ".we"},   32'(bus.dmem_we_o), 32'(in.kind == 2));
                if (in.kind == 2) begin
                    chk({tag, ".be"},    32'(bus.dmem_be_o), 32'(m_be(in.size, in.addr)));
                    chk({tag, ".wdata"}, bus.dmem_wdata_o,   m_wdata(in.size, in.data));
                    obs_be    = bus.dmem_be_o;
                    obs_wdata = bus.dmem_wdata_o;
                end
            end
            @(posedge clk);
            #1;
            if (c < last) begin
                chk_wb({tag, ".bubble"}, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            end else if (!in.valid) begin
                chk_wb({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            end else if (!mem) begin
                chk_wb({tag, ".alu"}, in.rfwe, 1'b0, 1'b0, 1'b0, in.waddr, in.addr, '0);
            end else if (!acc) begin
                chk_wb({tag, ".misalign"}, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
            end else if (in.lat < 0) begin
                chk_wb({tag, ".timeout"}, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
            end else begin
                chk_wb({tag, ".done"}, in.rfwe, in.kind == 1, 1'b0, 1'b0, in.waddr, in.addr,
                       m_load(in.size, in.uns, in.addr, rd));
            end
        end
    endtask

    initial begin
        instr_t t;
        // Reset with an access and a stray ack on the inputs
        rst = 1'b1;
        drive(mk(1'b1, 1, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'd3, 0));
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset.req",   32'(bus.dmem_req_o), 32'd0);
            chk("reset.stall", 32'(stall_o),        32'd0);
            @(posedge clk); #1;
            chk_all_zero("reset");
        end
        @(negedge clk);
        rst = 1'b0;
        bus.dmem_ack_i = 1'b0;
        valid_i = 1'b0;

        // ALU op
        run_instr("alu", mk(1'b1, 0, 2'b10, 1'b0, 32'h1234, 32'h0, 1'b1, 32'd5, 0));
        chk("alu.lit_waddr", rf_waddr_o,   32'd5);
        chk("alu.lit_alu",   alu_result_o, 32'h1234);

        // LB / LBU zero-wait
        t = mk(1'b1, 1, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 32'd7, 0);
        t.rdfix = 1'b1; t.rdv = 32'h80FF_FFFF;
        run_instr("lb", t);
        chk("lb.lit_rdata", mem_rdata_o, 32'hFFFF_FF80);
        t.uns = 1'b1;
        run_instr("lbu", t);
        chk("lbu.lit_rdata", mem_rdata_o, 32'h0000_0080);

        // SH with three wait states
        run_instr("sh", mk(1'b1, 2, 2'b01, 1'b0, 32'h22, 32'hABCD_1234, 1'b0, 32'd0, 3));
        chk("sh.lit_be",    32'(obs_be), 32'h0000_000C);
        chk("sh.lit_wdata", obs_wdata,   32'h1234_1234);

        // Misaligned LW, aligned LH
        run_instr("lw_mis", mk(1'b1, 1, 2'b10, 1'b0, 32'h41, 32'h0, 1'b1, 32'd9, 0));
        chk("lw_mis.lit_misalign", 32'(misalign_o), 32'd1);
        run_instr("lh", mk(1'b1, 1, 2'b01, 1'b0, 32'h42, 32'h0, 1'b1, 32'd10, 1));

        // Reset while waiting; a late ack must not write back
        @(negedge clk);
        drive(mk(1'b1, 1, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 32'd11, -1));
        bus.dmem_ack_i = 1'b0;
        #1;
        chk("rstwait.req0", 32'(bus.dmem_req_o), 32'd1);
        @(negedge clk); #1;
        chk("rstwait.req1", 32'(bus.dmem_req_o), 32'd1);
        chk("rstwait.stall1", 32'(stall_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwait.req_rst",   32'(bus.dmem_req_o), 32'd0);
        chk("rstwait.stall_rst", 32'(stall_o),        32'd0);
        @(posedge clk); #1;
        chk_all_zero("rstwait");
        @(negedge clk);
        rst = 1'b0;
        valid_i = 1'b0;
        bus.dmem_ack_i = 1'b1;
        #1;
        chk("rstwait.req_after",   32'(bus.dmem_req_o), 32'd0);
        chk("rstwait.stall_after", 32'(stall_o),        32'd0);
        @(posedge clk); #1;
        chk("rstwait.late_rf_we",  32'(rf_we_o),  32'd0);
        chk("rstwait.late_mem2rf", 32'(mem2rf_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
        run_instr("timeout", mk(1'b1, 1, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 32'd12, -1));
        @(negedge clk);
        valid_i = 1'b0;
        bus.dmem_ack_i = 1'b1;
        #1;
        chk("timeout.stall_released", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("timeout.pulse_once", 32'(bus_err_o), 32'd0);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            int          r;
            int          lat;
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            r = int'($urandom_range(0, 9));
            if (r < 4)       lat = 0;
            else if (r < 8)  lat = int'($urandom_range(1, 3));
`ifdef MEM_TIMEOUT_EN
            else if (r == 9) lat = -1;
`endif
            else             lat = 6;
            t = mk($urandom_range(0, 7) != 0, int'($urandom_range(0, 2)), sz,
                   bit'($urandom_range(0, 1)), a, $urandom,
                   bit'($urandom_range(0, 1)), $urandom, lat);
            run_instr("rand", t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, between execute and writeback_stage.
- Issues loads and stores to the data memory over a req/ack handshake and stalls upstream while an access is outstanding.
- Aligns and extends load data and presents the registered MEM/WB pipeline signals that writeback_stage consumes directly.

Parameters:
- TIMEOUT_CYCLES, 255: wait cycles after which an unacknowledged access is aborted. Active only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  instruction present from execute
- rf_we_i  in  1  register-file write enable
- rf_waddr_i  in  32  destination register; only [4:0] significant
- mem_re_i  in  1  load
- mem_we_i  in  1  store
- mem_size_i  in  2  00 byte, 01 half, 10 word
- mem_unsigned_i  in  1  zero-extend load (LBU/LHU)
- alu_result_i  in  32  effective address, or ALU result
- store_data_i  in  32  rs2 value
- stall_o  out  1  hold execute/decode/fetch
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  write
- dmem_addr_o  out  32  word-aligned address, [1:0]=0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_ack_i  in  1  access complete; rdata valid this cycle
- dmem_rdata_i  in  32  read word
- rf_we_o  out  1  to writeback_stage
- rf_waddr_o  out  32  to writeback_stage
- mem2rf_o  out  1  select load data in writeback
- mem_rdata_o  out  32  aligned, extended load data
- alu_result_o  out  32  to writeback_stage
- misalign_o  out  1  one-cycle misaligned-access flag
- bus_err_o  out  1  one-cycle timeout flag (0 without macro)

Behaviour:
- Reset: all registered outputs are 0 and the FSM is in IDLE. While rst is high, dmem_req_o=0 and stall_o=0.
- access = valid_i & (mem_re_i | mem_we_i) & aligned.
- aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=0; size 11 is treated as word.
- FSM IDLE:
  - If access, drive dmem_req_o=1 combinationally from the inputs.
  - If dmem_ack_i is also high (zero-wait), complete the access this cycle and stay IDLE.
  - Otherwise latch addr, be, wdata, we, size, unsigned, rf_we and waddr, then go to WAIT.
- FSM WAIT:
  - dmem_req_o=1, with all request fields taken from the latches and held stable.
  - On dmem_ack_i, complete and return to IDLE.
- stall_o = access-pending & ~dmem_ack_i, i.e. (IDLE & access & ~ack) | (WAIT & ~ack). Upstream holds its inputs stable while stall_o=1.
- Completion / non-memory instruction: at the clock edge, the MEM/WB registers load the instruction's fields. Latency is 1 cycle plus memory wait states.
- While stalled, and for valid_i=0, the MEM/WB registers load a bubble: rf_we_o=0, mem2rf_o=0, misalign_o=0.
- Store byte enables (off = addr[1:0]):
  - byte: 0001<<off
  - half: 0011<<off
  - word: 1111
- Store write data:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- Load data: take the byte at off or the half at off[1] from dmem_rdata_i, then sign- or zero-extend to 32 per mem_unsigned. Word loads pass the read word through.
- mem2rf_o = load completed. rf_we_o follows rf_we_i. alu_result_o follows alu_result_i (the address).
- Misaligned load/store:
  - No request and no stall.
  - Registered outputs: rf_we_o=0, mem2rf_o=0, misalign_o=1 for one cycle.
- dmem_ack_i in IDLE with no request is ignored.
- Reset in WAIT: return to IDLE, drop dmem_req_o in the reset cycle, and ignore any late ack.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- With the macro:
  - An 8+-bit wait counter clears on entering WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the access aborts: drop req, return to IDLE, release stall.
  - MEM/WB loads rf_we_o=0, mem2rf_o=0, bus_err_o=1 for one cycle.
- Without the macro: WAIT persists until ack, and bus_err_o is tied to 0.

Test Plan:
- ALU op (mem_re=mem_we=0, rf_we=1, waddr=5, alu=0x1234): next cycle rf_we_o=1, rf_waddr_o=5, alu_result_o=0x1234, mem2rf_o=0; no req, no stall.
- LB, addr 0x103, rdata 0x80FF_FF_FF, ack same cycle: stall_o=0; dmem_addr_o=0x100, be=0000-independent read; next cycle mem_rdata_o=0xFFFFFF80, mem2rf_o=1. LBU gives 0x00000080.
- SH, addr 0x22, data 0xABCD1234, ack after 3 wait cycles: be=1100, wdata=0x12341234; stall_o high exactly 3 cycles; req fields stable; then rf_we_o=0.
- LW at addr 0x41: no req, misalign_o=1 for one cycle, rf_we_o=0. LH at addr 0x42: aligned and issued.
- rst asserted in WAIT: next cycle dmem_req_o=0, stall_o=0, outputs 0; an ack arriving afterwards produces no writeback.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives: bus_err_o pulses once after 4 wait cycles, stall released, rf_we_o=0.
